// File: rtl/demux_framing_ctrl_if.sv
// Symbol-in / lane-out bundle for the receive framing controller.
// master drives valid/data; slave (the controller) drives the lane side.
interface demux_framing_ctrl_if;
  logic       valid;
  logic [7:0] data;
  logic [3:0] lane_we;
  logic [7:0] lane_data;
  logic [7:0] control;
  logic       aligned;
  logic       pkt_active;
  logic [7:0] pkt_len;
  logic       pkt_done;
  logic       pkt_err;

  modport master (
    output valid, data,
    input  lane_we, lane_data, control, aligned,
    input  pkt_active, pkt_len, pkt_done, pkt_err
  );

  modport slave (
    input  valid, data,
    output lane_we, lane_data, control, aligned,
    output pkt_active, pkt_len, pkt_done, pkt_err
  );
endinterface

// File: rtl/demux_framing_ctrl.sv
// Receive framing controller: COM alignment, STP/SDP..END/EDB framing,
// one-hot lane strobes. Ports: clk_1m, reset_L (sync, active-low), bus
// (slave: valid,data in; lane_we,lane_data,control,aligned,pkt_active,
// pkt_len,pkt_done,pkt_err out). Macro SKP_DROP_EN drops SKP when ALIGNED.
module demux_framing_ctrl #(
  parameter int COM_N = 4
) (
  input logic                 clk_1m,
  input logic                 reset_L,
  demux_framing_ctrl_if.slave bus
);
  typedef enum logic [1:0] {
    UNALIGNED = 2'd0,
    ALIGNED   = 2'd1,
    PKT       = 2'd2
  } state_t;

  localparam logic [7:0] STP = 8'hFB;
  localparam logic [7:0] SDP = 8'h5C;
  localparam logic [7:0] ENDS = 8'hFD;
  localparam logic [7:0] EDB = 8'hFE;
  localparam logic [7:0] SKP = 8'h1C;
  localparam logic [7:0] IDL = 8'h7C;
  localparam logic [7:0] FTS = 8'h3C;
  localparam logic [7:0] COM = 8'hBC;

  state_t     state_q, state_d;
  logic [1:0] lp_q, lp_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] len_q, len_d;
  logic [3:0] we_q, we_d;
  logic [7:0] ldat_q, ldat_d;
  logic [7:0] ctl_q, ctl_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic       is_ctl;
  logic       wr;

  always_comb begin
    state_d = state_q;
    lp_d    = lp_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    we_d    = '0;
    ldat_d  = ldat_q;
    ctl_d   = '0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    wr      = 1'b0;
    is_ctl  = bus.data inside
      {STP, SDP, ENDS, EDB, SKP, IDL, FTS, COM};
    if (bus.valid) begin
      unique case (state_q)
        UNALIGNED: begin
          ctl_d = is_ctl ? bus.data : '0;
          if (bus.data == COM) begin
            if (cnt_q == 4'(COM_N - 1)) begin
              state_d = ALIGNED;
              lp_d    = '0;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end else begin
            cnt_d = '0;
          end
        end
        ALIGNED: begin
          ctl_d = is_ctl ? bus.data : '0;
          unique case (1'b1)
            (bus.data == COM): lp_d = '0;
            (bus.data == STP) || (bus.data == SDP): begin
              wr      = 1'b1;
              len_d   = '0;
              state_d = PKT;
            end
`ifdef SKP_DROP_EN
            (bus.data == SKP): wr = 1'b0;
`else
            (bus.data == SKP): wr = 1'b1;
`endif
            (bus.data == IDL) || (bus.data == FTS): wr = 1'b1;
            (bus.data == ENDS) || (bus.data == EDB): err_d = 1'b1;
            default: begin
              err_d   = 1'b1;
              state_d = UNALIGNED;
              cnt_d   = '0;
            end
          endcase
        end
        PKT: begin
          wr = 1'b1;
          if (bus.data == ENDS) begin
            ctl_d   = ENDS;
            done_d  = 1'b1;
            state_d = ALIGNED;
          end else if (bus.data == EDB) begin
            ctl_d   = EDB;
            err_d   = 1'b1;
            state_d = ALIGNED;
          end else if (len_q != 8'hFF) begin
            len_d = len_q + 8'd1;
          end
        end
        default: state_d = UNALIGNED;
      endcase
      if (wr) begin
        we_d   = 4'b0001 << lp_q;
        ldat_d = bus.data;
        lp_d   = lp_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk_1m) begin
    if (!reset_L) begin
      state_q <= UNALIGNED;
      lp_q    <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      we_q    <= '0;
      ldat_q  <= '0;
      ctl_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lp_q    <= lp_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      we_q    <= we_d;
      ldat_q  <= ldat_d;
      ctl_q   <= ctl_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.lane_we    = we_q;
  assign bus.lane_data  = ldat_q;
  assign bus.control    = ctl_q;
  assign bus.aligned    = (state_q != UNALIGNED);
  assign bus.pkt_active = (state_q == PKT);
  assign bus.pkt_len    = len_q;
  assign bus.pkt_done   = done_q;
  assign bus.pkt_err    = err_q;
endmodule

// File: tb/tb_demux_framing_ctrl.sv
// Bench for demux_framing_ctrl: directed table, corner sequences and
// randomized traffic against a behavioural framing model.
module tb_demux_framing_ctrl;
  localparam int COM_N = 4;
`ifdef SKP_DROP_EN
  localparam bit SKPD = 1'b1;
`else
  localparam bit SKPD = 1'b0;
`endif

  logic clk_1m = 1'b0;
  logic reset_L = 1'b0;
  demux_framing_ctrl_if bus ();

  demux_framing_ctrl #(.COM_N(COM_N)) dut (
    .clk_1m (clk_1m),
    .reset_L(reset_L),
    .bus    (bus.slave)
  );

  always #5 clk_1m = ~clk_1m;

  int total = 0;
  int bad = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // behavioural model: mode 0=unaligned 1=aligned 2=in packet
  int m_mode = 0, m_lp = 0, m_coms = 0, m_len = 0;
  logic [3:0] e_we;
  logic [7:0] e_ld = 0, e_ctl;
  logic e_done, e_err, ld_chk, ctl_chk;

  function automatic bit is_code(logic [7:0] d);
    return d == 8'hFB || d == 8'h5C || d == 8'hFD || d == 8'hFE ||
           d == 8'h1C || d == 8'h7C || d == 8'h3C || d == 8'hBC;
  endfunction

  task automatic model(bit rn, bit v, logic [7:0] d);
    bit w;
    w = 0;
    e_we = 0; e_ctl = 0; e_done = 0; e_err = 0;
    ld_chk = 0; ctl_chk = 1;
    if (!rn) begin
      m_mode = 0; m_lp = 0; m_coms = 0; m_len = 0;
      e_ld = 0; ld_chk = 1;
    end else if (v) begin
      case (m_mode)
        0: begin
          ctl_chk = 0;
          if (d == 8'hBC) begin
            m_coms++;
            if (m_coms == COM_N) begin
              m_mode = 1; m_lp = 0; m_coms = 0;
            end
          end else m_coms = 0;
        end
        1: begin
          e_ctl = is_code(d) ? d : 8'h00;
          if (d == 8'hBC) m_lp = 0;
          else if (d == 8'hFB || d == 8'h5C) begin
            w = 1; m_len = 0; m_mode = 2;
          end
          else if (d == 8'h1C) w = !SKPD;
          else if (d == 8'h7C || d == 8'h3C) w = 1;
          else if (d == 8'hFD || d == 8'hFE) e_err = 1;
          else begin
            e_err = 1; m_mode = 0; m_coms = 0;
          end
        end
        default: begin
          w = 1;
          if (d == 8'hFD) begin
            e_done = 1; m_mode = 1; e_ctl = d;
          end else if (d == 8'hFE) begin
            e_err = 1; m_mode = 1; e_ctl = d;
          end else if (m_len < 255) m_len++;
        end
      endcase
      if (w) begin
        e_we = 4'(1 << m_lp);
        e_ld = d; ld_chk = 1;
        m_lp = (m_lp + 1) % 4;
      end
    end
  endtask

  task automatic check_model(string t);
    chk({t, ".we"}, 32'(bus.lane_we), 32'(e_we));
    if (ld_chk) chk({t, ".data"}, 32'(bus.lane_data), 32'(e_ld));
    if (ctl_chk) chk({t, ".ctl"}, 32'(bus.control), 32'(e_ctl));
    chk({t, ".al"}, 32'(bus.aligned), 32'(m_mode != 0));
    chk({t, ".act"}, 32'(bus.pkt_active), 32'(m_mode == 2));
    chk({t, ".len"}, 32'(bus.pkt_len), 32'(m_len));
    chk({t, ".done"}, 32'(bus.pkt_done), 32'(e_done));
    chk({t, ".err"}, 32'(bus.pkt_err), 32'(e_err));
  endtask

  task automatic drive(bit rn, bit v, logic [7:0] d);
    reset_L = rn; bus.valid = v; bus.data = d;
    @(posedge clk_1m);
    model(rn, v, d);
    #1;
  endtask

  task automatic step(bit rn, bit v, logic [7:0] d, string t);
    drive(rn, v, d);
    check_model(t);
  endtask

  typedef struct {
    bit rn; bit v; logic [7:0] d;
    logic [3:0] we; logic [7:0] ld; logic [7:0] ctl; bit cc;
    bit al; bit act; logic [7:0] len; bit done; bit err;
  } vec_t;
  vec_t tv[$];

  initial begin
    logic [7:0] codes[8];
    logic [7:0] d;
    vec_t x;
    codes = '{8'hFB, 8'h5C, 8'hFD, 8'hFE, 8'h1C, 8'h7C, 8'h3C, 8'hBC};
    bus.valid = 0; bus.data = 0;

    //          rn v  d      we       ld     ctl  cc al act len done err
    tv.push_back('{0, 0, 8'h00, 4'b0000, 8'h00, 8'h00, 1, 0, 0, 0, 0, 0});
    for (int i = 0; i < 3; i++)
      tv.push_back('{1, 1, 8'hBC, 4'b0000, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0});
    tv.push_back('{1, 1, 8'hBC, 4'b0000, 8'h00, 8'h00, 0, 1, 0, 0, 0, 0});
    tv.push_back('{1, 1, 8'hFB, 4'b0001, 8'hFB, 8'hFB, 1, 1, 1, 0, 0, 0});
    tv.push_back('{1, 1, 8'h01, 4'b0010, 8'h01, 8'h00, 1, 1, 1, 1, 0, 0});
    tv.push_back('{1, 1, 8'h02, 4'b0100, 8'h02, 8'h00, 1, 1, 1, 2, 0, 0});
    tv.push_back('{1, 1, 8'hFD, 4'b1000, 8'hFD, 8'hFD, 1, 1, 0, 2, 1, 0});
    for (int i = 0; i < 4; i++)
      tv.push_back('{1, 1, 8'h1C, SKPD ? 4'b0000 : 4'(1 << i),
                     8'h1C, 8'h1C, 1, 1, 0, 2, 0, 0});
    tv.push_back('{1, 1, 8'h5C, 4'b0001, 8'h5C, 8'h5C, 1, 1, 1, 0, 0, 0});
    tv.push_back('{1, 1, 8'h0D, 4'b0010, 8'h0D, 8'h00, 1, 1, 1, 1, 0, 0});
    tv.push_back('{1, 1, 8'hFE, 4'b0100, 8'hFE, 8'hFE, 1, 1, 0, 1, 0, 1});
    tv.push_back('{1, 1, 8'hFD, 4'b0000, 8'h00, 8'hFD, 1, 1, 0, 1, 0, 1});
    tv.push_back('{1, 0, 8'hFB, 4'b0000, 8'h00, 8'h00, 1, 1, 0, 1, 0, 0});

    foreach (tv[i]) begin
      x = tv[i];
      drive(x.rn, x.v, x.d);
      chk($sformatf("tv%0d.we", i), 32'(bus.lane_we), 32'(x.we));
      if (x.we != 0)
        chk($sformatf("tv%0d.data", i), 32'(bus.lane_data), 32'(x.ld));
      if (x.cc)
        chk($sformatf("tv%0d.ctl", i), 32'(bus.control), 32'(x.ctl));
      chk($sformatf("tv%0d.al", i), 32'(bus.aligned), 32'(x.al));
      chk($sformatf("tv%0d.act", i), 32'(bus.pkt_active), 32'(x.act));
      chk($sformatf("tv%0d.len", i), 32'(bus.pkt_len), 32'(x.len));
      chk($sformatf("tv%0d.done", i), 32'(bus.pkt_done), 32'(x.done));
      chk($sformatf("tv%0d.err", i), 32'(bus.pkt_err), 32'(x.err));
    end

    // gap mid-packet: lp and pkt_len hold across invalid cycles
    step(1, 1, 8'hBC, "gap_com");
    step(1, 1, 8'hFB, "gap_stp");
    step(1, 1, 8'h01, "gap_p1");
    for (int i = 0; i < 3; i++) step(1, 0, 8'hFD, "gap_idle");
    step(1, 1, 8'h0A, "gap_p2");
    chk("gap_lane", 32'(bus.lane_we), 32'h4);
    step(1, 1, 8'hFD, "gap_end");
    chk("gap_len", 32'(bus.pkt_len), 32'd2);

    // reset mid-packet, then STP ignored until re-aligned
    step(1, 1, 8'h5C, "rp_sdp");
    step(1, 1, 8'h33, "rp_p");
    step(0, 1, 8'h44, "rp_rst");
    chk("rp_al", 32'(bus.aligned), 32'd0);
    step(1, 1, 8'hFB, "rp_stp");
    chk("rp_nowe", 32'(bus.lane_we), 32'd0);
    for (int i = 0; i < 4; i++) step(1, 1, 8'hBC, "rp_com");
    chk("rp_realign", 32'(bus.aligned), 32'd1);

    // back-to-back packets and pkt_len saturation
    step(1, 1, 8'hFB, "sat_stp");
    for (int i = 0; i < 300; i++) step(1, 1, 8'h11, "sat_p");
    chk("sat_len", 32'(bus.pkt_len), 32'd255);
    step(1, 1, 8'hFD, "sat_end");
    step(1, 1, 8'h5C, "b2b_sdp");
    chk("b2b_act", 32'(bus.pkt_active), 32'd1);
    step(1, 1, 8'hFD, "b2b_end");

    // COM x3 then other byte: no alignment
    step(0, 0, 8'h00, "c3_rst");
    for (int i = 0; i < 3; i++) step(1, 1, 8'hBC, "c3_com");
    step(1, 1, 8'h01, "c3_x");
    step(1, 1, 8'hBC, "c3_com2");
    chk("c3_al", 32'(bus.aligned), 32'd0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if (m_mode == 0 && $urandom_range(0, 9) < 8) d = 8'hBC;
      else if ($urandom_range(0, 1) == 0) d = codes[$urandom_range(0, 7)];
      else d = 8'($urandom);
      step($urandom_range(0, 199) != 0, $urandom_range(0, 4) != 0, d,
           "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
